// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decrypt datapath stages: FSM encodings,
// state size, the InvShiftRows source mapping and the inverse S-box table.
package aes_dec_pkg;

    localparam int NUM_BYTES = 16;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_RD   = 5'b00010,
        ST_RDW  = 5'b00100,
        ST_WR   = 5'b01000,
        ST_DONE = 5'b10000
    } state_t;

    // Byte d = r + 4c takes its value from column (c - r) mod 4 of the same row.
    function automatic logic [3:0] inv_shift_src(input logic [3:0] d);
        logic [1:0] w_row;
        logic [1:0] w_col;
        w_row = d[1:0];
        w_col = d[3:2] - d[1:0];
        return {w_col, w_row};
    endfunction

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox_rom.sv
// Combinational FIPS-197 inverse S-box lookup, 8 bits in, 8 bits out.
module inv_sbox_rom
    import aes_dec_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_shift_row_sub.sv
// InvShiftRows + InvSubBytes over the 16-byte statemt RAM: 8 read pairs, 1 drain
// cycle, 8 write pairs, then a done/ready pulse; ap_start is ignored while busy.
module inv_shift_row_sub
    import aes_dec_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 32
)(
    input  logic          ap_clk,
    input  logic          ap_rst,
    input  logic          ap_start,
    output logic          ap_done,
    output logic          ap_idle,
    output logic          ap_ready,
    output logic [AW-1:0] statemt_address0,
    output logic          statemt_ce0,
    output logic          statemt_we0,
    output logic [DW-1:0] statemt_d0,
    input  logic [DW-1:0] statemt_q0,
    output logic [AW-1:0] statemt_address1,
    output logic          statemt_ce1,
    output logic          statemt_we1,
    output logic [DW-1:0] statemt_d1,
    input  logic [DW-1:0] statemt_q1
);

    state_t     r_state;
    logic [2:0] r_k;
    logic [7:0] r_buf [NUM_BYTES];

    logic       w_rd;
    logic       w_wr;
    logic [2:0] w_k_prev;
    logic [3:0] w_addr0;
    logic [3:0] w_addr1;
    logic [7:0] w_sub0;
    logic [7:0] w_sub1;
    logic       w_unused_q;

    assign w_rd     = (r_state == ST_RD);
    assign w_wr     = (r_state == ST_WR);
    assign w_k_prev = r_k - 3'd1;
    assign w_addr0  = {r_k, 1'b0};
    assign w_addr1  = {r_k, 1'b1};

    // Only the low byte of each word carries state.
    assign w_unused_q = ^{statemt_q0[DW-1:8], statemt_q1[DW-1:8]};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
            r_k     <= 3'd0;
            for (int i = 0; i < NUM_BYTES; i++) begin
                r_buf[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_state <= ST_RD;
                        r_k     <= 3'd0;
                    end
                end
                ST_RD: begin
                    // Read data lags the address by one cycle, so capture the previous pair.
                    if (r_k != 3'd0) begin
                        r_buf[{w_k_prev, 1'b0}] <= statemt_q0[7:0];
                        r_buf[{w_k_prev, 1'b1}] <= statemt_q1[7:0];
                    end
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_state <= ST_RDW;
                    end
                end
                ST_RDW: begin
                    r_buf[14] <= statemt_q0[7:0];
                    r_buf[15] <= statemt_q1[7:0];
                    r_k       <= 3'd0;
                    r_state   <= ST_WR;
                end
                ST_WR: begin
                    r_k <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    inv_sbox_rom u_sbox0 (
        .i_byte (r_buf[inv_shift_src(w_addr0)]),
        .o_byte (w_sub0)
    );

    inv_sbox_rom u_sbox1 (
        .i_byte (r_buf[inv_shift_src(w_addr1)]),
        .o_byte (w_sub1)
    );

    assign statemt_ce0      = w_rd | w_wr;
    assign statemt_ce1      = w_rd | w_wr;
    assign statemt_we0      = w_wr;
    assign statemt_we1      = w_wr;
    assign statemt_address0 = (w_rd | w_wr) ? {{(AW-4){1'b0}}, w_addr0} : '0;
    assign statemt_address1 = (w_rd | w_wr) ? {{(AW-4){1'b0}}, w_addr1} : '0;
    assign statemt_d0       = w_wr ? {{(DW-8){1'b0}}, w_sub0} : '0;
    assign statemt_d1       = w_wr ? {{(DW-8){1'b0}}, w_sub1} : '0;

    assign ap_done  = (r_state == ST_DONE);
    assign ap_ready = (r_state == ST_DONE);
    assign ap_idle  = (r_state == ST_IDLE) & ~ap_start;

endmodule

// File: tb/tb_inv_shift_row_sub.sv
// Bench for inv_shift_row_sub: behavioural dual-port RAM plus a write scoreboard
// fed from an independent GF(2^8) inverse S-box model.
module tb_inv_shift_row_sub;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic [4:0]  statemt_address0, statemt_address1;
    logic        statemt_ce0, statemt_we0, statemt_ce1, statemt_we1;
    logic [31:0] statemt_d0, statemt_d1;
    logic [31:0] statemt_q0 = '0;
    logic [31:0] statemt_q1 = '0;

    logic [31:0] mem [32];
    wr_t         sb_q [$];
    int          total = 0;
    int          bad = 0;

    always #5 ap_clk = ~ap_clk;

    inv_shift_row_sub dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .ap_start         (ap_start),
        .ap_done          (ap_done),
        .ap_idle          (ap_idle),
        .ap_ready         (ap_ready),
        .statemt_address0 (statemt_address0),
        .statemt_ce0      (statemt_ce0),
        .statemt_we0      (statemt_we0),
        .statemt_d0       (statemt_d0),
        .statemt_q0       (statemt_q0),
        .statemt_address1 (statemt_address1),
        .statemt_ce1      (statemt_ce1),
        .statemt_we1      (statemt_we1),
        .statemt_d1       (statemt_d1),
        .statemt_q1       (statemt_q1)
    );

    // Dual-port RAM with one-cycle read latency.
    always @(posedge ap_clk) begin
        if (statemt_ce0) begin
            if (statemt_we0) mem[statemt_address0] = statemt_d0;
            else             statemt_q0 <= mem[statemt_address0];
        end
        if (statemt_ce1) begin
            if (statemt_we1) mem[statemt_address1] = statemt_d1;
            else             statemt_q1 <= mem[statemt_address1];
        end
    end

    // Write scoreboard: each DUT write pops the next expected (address, data).
    always @(negedge ap_clk) begin
        wr_t e;
        if (!ap_rst && statemt_ce0 && statemt_we0) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL wr0_unexpected got addr=%0d data=%h want no write", statemt_address0, statemt_d0);
            end else begin
                e = sb_q.pop_front();
                if (statemt_address0 !== e.addr || statemt_d0 !== e.data) begin
                    bad++;
                    $display("FAIL wr0 got addr=%0d data=%h want addr=%0d data=%h",
                             statemt_address0, statemt_d0, e.addr, e.data);
                end
            end
        end
        if (!ap_rst && statemt_ce1 && statemt_we1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL wr1_unexpected got addr=%0d data=%h want no write", statemt_address1, statemt_d1);
            end else begin
                e = sb_q.pop_front();
                if (statemt_address1 !== e.addr || statemt_d1 !== e.data) begin
                    bad++;
                    $display("FAIL wr1 got addr=%0d data=%h want addr=%0d data=%h",
                             statemt_address1, statemt_d1, e.addr, e.data);
                end
            end
        end
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Inverse affine transform followed by multiplicative inverse in GF(2^8).
    function automatic logic [7:0] model_inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] v8;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        r = 8'h00;
        for (int v = 1; v < 256; v++) begin
            v8 = v[7:0];
            if (gmul(b, v8) == 8'h01) r = v8;
        end
        return r;
    endfunction

    task automatic push_expected();
        wr_t e;
        int  r, c, src;
        for (int d = 0; d < 16; d++) begin
            r = d % 4;
            c = d / 4;
            src = r + 4 * ((c - r + 4) % 4);
            e.addr = d[4:0];
            e.data = {24'h0, model_inv_sbox(mem[src][7:0])};
            sb_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        total++;
        if ({statemt_ce0, statemt_we0, statemt_ce1, statemt_we1} !== 4'b0) begin
            bad++;
            $display("FAIL rst_ce_we got=%b want=0000", {statemt_ce0, statemt_we0, statemt_ce1, statemt_we1});
        end
        total++;
        if (statemt_address0 !== 5'd0 || statemt_address1 !== 5'd0 || statemt_d0 !== 32'd0 || statemt_d1 !== 32'd0) begin
            bad++;
            $display("FAIL rst_addr_data got a0=%0d a1=%0d d0=%h d1=%h want all 0",
                     statemt_address0, statemt_address1, statemt_d0, statemt_d1);
        end
        total++;
        if ({ap_done, ap_ready, ap_idle} !== 3'b001) begin
            bad++;
            $display("FAIL rst_handshake got done/ready/idle=%b want=001", {ap_done, ap_ready, ap_idle});
        end
        ap_rst = 1'b0;
        @(negedge ap_clk);
        total++;
        if (ap_idle !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_idle got=%b want=1", ap_idle);
        end
    endtask

    task automatic test_all_63();
        logic [31:0] upper [16];
        int nz;
        for (int i = 0; i < 32; i++) mem[i] = (i < 16) ? 32'h63 : (32'hA5A50000 | i);
        for (int i = 0; i < 16; i++) upper[i] = mem[16 + i];
        push_expected();
        ap_start = 1'b1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge ap_clk);
            total++;
            if (ap_done !== (cyc == 18) || ap_ready !== (cyc == 18)) begin
                bad++;
                $display("FAIL all63_done cyc=%0d got done=%b ready=%b want=%b", cyc, ap_done, ap_ready, cyc == 18);
            end
            if (cyc == 19) begin
                total++;
                if (ap_idle !== 1'b1) begin
                    bad++;
                    $display("FAIL all63_idle19 got=%b want=1", ap_idle);
                end
            end
            if (cyc == 1) ap_start = 1'b0;
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 32'h0) nz++;
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL all63_ram got nonzero_words=%0d want=0", nz);
        end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem[16 + i] !== upper[i]) nz++;
        total++;
        if (nz != 0) begin
            bad++;
            $display("FAIL all63_upper got changed_words=%0d want=0", nz);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL all63_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    task automatic test_identity();
        logic [31:0] want [4];
        int          idx [4];
        for (int i = 0; i < 32; i++) mem[i] = i;
        mem[16] = 32'hDEADBEEF;
        push_expected();
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (18) @(negedge ap_clk);
        idx[0] = 0; want[0] = 32'h52;
        idx[1] = 5; want[1] = 32'h09;
        idx[2] = 1; want[2] = 32'hf3;
        idx[3] = 4; want[3] = 32'h30;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[idx[i]] !== want[i]) begin
                bad++;
                $display("FAIL ident_word%0d got=%h want=%h", idx[i], mem[idx[i]], want[i]);
            end
        end
        total++;
        if (mem[16] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL ident_word16 got=%h want=deadbeef", mem[16]);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL ident_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    task automatic test_upper_bits();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[0] = 32'hFFFFFF63;
        push_expected();
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (18) @(negedge ap_clk);
        total++;
        if (mem[0] !== 32'h0) begin
            bad++;
            $display("FAIL upper_word0 got=%h want=00000000", mem[0]);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL upper_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_wr();
        logic [31:0] old6, old7;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        old6 = mem[6];
        old7 = mem[7];
        push_expected();
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge ap_clk);
            if (cyc == 1) ap_start = 1'b0;
        end
        @(posedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        total++;
        if ({statemt_ce0, statemt_we0, statemt_ce1, statemt_we1} !== 4'b0) begin
            bad++;
            $display("FAIL midrst_ce_we got=%b want=0000", {statemt_ce0, statemt_we0, statemt_ce1, statemt_we1});
        end
        total++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            bad++;
            $display("FAIL midrst_state got idle=%b done=%b want idle=1 done=0", ap_idle, ap_done);
        end
        total++;
        if (sb_q.size() != 10) begin
            bad++;
            $display("FAIL midrst_partial got pending=%0d want=10", sb_q.size());
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        sb_q.delete();
        total++;
        if (mem[6] !== old6 || mem[7] !== old7) begin
            bad++;
            $display("FAIL midrst_k3 got w6=%h w7=%h want w6=%h w7=%h", mem[6], mem[7], old6, old7);
        end
        @(negedge ap_clk);
        push_expected();
        ap_start = 1'b1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            @(negedge ap_clk);
            total++;
            if (ap_done !== (cyc == 18)) begin
                bad++;
                $display("FAIL midrst_rerun_done cyc=%0d got=%b want=%b", cyc, ap_done, cyc == 18);
            end
            if (cyc == 1) ap_start = 1'b0;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL midrst_rerun_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        @(negedge ap_clk);
        push_expected();
        ap_start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) ndone++;
            total++;
            if (ap_done !== (cyc == 18 || cyc == 37) || ap_ready !== ap_done) begin
                bad++;
                $display("FAIL b2b_done cyc=%0d got done=%b ready=%b want=%b", cyc, ap_done, ap_ready,
                         (cyc == 18 || cyc == 37));
            end
            if (cyc == 18) push_expected();
            if (cyc == 19) begin
                total++;
                if (ap_idle !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_idle19 got=%b want=0", ap_idle);
                end
            end
            if (cyc == 38) begin
                ap_start = 1'b0;
                #1;
                total++;
                if (ap_idle !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_idle38 got=%b want=1", ap_idle);
                end
            end
        end
        total++;
        if (ndone != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", ndone);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    task automatic test_start_during_rd();
        int ndone;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        @(negedge ap_clk);
        push_expected();
        ap_start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge ap_clk);
            if (ap_done === 1'b1) ndone++;
            total++;
            if (ap_done !== (cyc == 18) || ap_ready !== (cyc == 18)) begin
                bad++;
                $display("FAIL rdstart_done cyc=%0d got done=%b ready=%b want=%b", cyc, ap_done, ap_ready, cyc == 18);
            end
            if (cyc == 1) ap_start = 1'b0;
            if (cyc == 4) begin
                ap_start = 1'b1;
                #1;
                total++;
                if (ap_idle !== 1'b0) begin
                    bad++;
                    $display("FAIL rdstart_idle got=%b want=0", ap_idle);
                end
            end
            if (cyc == 5) ap_start = 1'b0;
            if (cyc == 19) begin
                total++;
                if (ap_idle !== 1'b1) begin
                    bad++;
                    $display("FAIL rdstart_idle19 got=%b want=1", ap_idle);
                end
            end
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL rdstart_count got=%0d want=1", ndone);
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL rdstart_writes got missing=%0d want=0", sb_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        test_reset();
        test_all_63();
        test_identity();
        test_upper_bits();
        test_reset_mid_wr();
        test_back_to_back();
        test_start_during_rd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
